// File: rtl/id_stage_hz.sv
// MIPS decode stage: control decoder, register file with optional WB->ID bypass,
// sign extender, ID/EX register, and load-use bubble insertion with flush/hold.
module id_stage_hz #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RA_W      = 5,
    parameter int unsigned BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       IF_ID_instrout,
    input  logic [DATA_W-1:0] IF_ID_npcout,
    input  logic [RA_W-1:0]   MEM_WB_rd,
    input  logic              MEM_WB_regwrite,
    input  logic [DATA_W-1:0] WB_mux5_writedata,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              stall_req,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic              regdst,
    output logic              alusrc,
    output logic [1:0]        aluop,
    output logic [DATA_W-1:0] npcout,
    output logic [DATA_W-1:0] rdata1out,
    output logic [DATA_W-1:0] rdata2out,
    output logic [DATA_W-1:0] s_extendout,
    output logic [RA_W-1:0]   instrout_2016,
    output logic [RA_W-1:0]   instrout_1511
);

    localparam int unsigned NumRegs = 2 ** RA_W;

    logic [5:0]        opcode;
    logic [RA_W-1:0]   rs_addr, rt_addr, rd_addr;
    logic signed [15:0] imm_s;
    logic [DATA_W-1:0] sext;

    assign opcode  = IF_ID_instrout[31:26];
    assign rs_addr = RA_W'(IF_ID_instrout[25:21]);
    assign rt_addr = RA_W'(IF_ID_instrout[20:16]);
    assign rd_addr = RA_W'(IF_ID_instrout[15:11]);
    assign imm_s   = IF_ID_instrout[15:0];
    assign sext    = DATA_W'(imm_s);

    logic [1:0] dec_wb;
    logic [2:0] dec_m;
    logic       dec_regdst, dec_alusrc;
    logic [1:0] dec_aluop;

    always_comb begin
        dec_wb     = 2'b00;
        dec_m      = 3'b000;
        dec_regdst = 1'b0;
        dec_alusrc = 1'b0;
        dec_aluop  = 2'b00;
        unique case (opcode)
            6'b000000: begin
                dec_wb     = 2'b10;
                dec_regdst = 1'b1;
                dec_aluop  = 2'b10;
            end
            6'b100011: begin
                dec_wb     = 2'b11;
                dec_m      = 3'b010;
                dec_alusrc = 1'b1;
            end
            6'b101011: begin
                dec_m      = 3'b001;
                dec_alusrc = 1'b1;
            end
            6'b000100: begin
                dec_m     = 3'b100;
                dec_aluop = 2'b01;
            end
            default: ;
        endcase
    end

    // Register file; r0 is never written, so it stays zero after reset.
    logic [DATA_W-1:0] rf_q [NumRegs];
    logic [DATA_W-1:0] rf_d [NumRegs];
    logic              wr_en;

    assign wr_en = MEM_WB_regwrite && (MEM_WB_rd != '0);

    always_comb begin
        rf_d = rf_q;
        if (wr_en) rf_d[MEM_WB_rd] = WB_mux5_writedata;
    end

    always_ff @(posedge clk) begin
        if (rst) rf_q <= '{default: '0};
        else     rf_q <= rf_d;
    end

    logic [DATA_W-1:0] rdata1, rdata2;

    always_comb begin
        rdata1 = rf_q[rs_addr];
        if ((BYPASS_EN != 0) && wr_en && (MEM_WB_rd == rs_addr)) rdata1 = WB_mux5_writedata;
        if (rs_addr == '0) rdata1 = '0;
        rdata2 = rf_q[rt_addr];
        if ((BYPASS_EN != 0) && wr_en && (MEM_WB_rd == rt_addr)) rdata2 = WB_mux5_writedata;
        if (rt_addr == '0) rdata2 = '0;
    end

    // ID/EX pipeline register
    logic [1:0]        wb_q, wb_d;
    logic [2:0]        m_q, m_d;
    logic              regdst_q, regdst_d, alusrc_q, alusrc_d;
    logic [1:0]        aluop_q, aluop_d;
    logic [DATA_W-1:0] npc_q, npc_d, rd1_q, rd1_d, rd2_q, rd2_d, sext_q, sext_d;
    logic [RA_W-1:0]   rt_q, rt_d, rd_q, rd_d;
    logic              hazard, bubble;

    assign hazard    = m_q[1] && (rt_q != '0) && ((rt_q == rs_addr) || (rt_q == rt_addr));
    assign stall_req = hazard || ex_hold;
    assign bubble    = ex_flush || hazard;

    always_comb begin
        wb_d     = wb_q;
        m_d      = m_q;
        regdst_d = regdst_q;
        alusrc_d = alusrc_q;
        aluop_d  = aluop_q;
        npc_d    = npc_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        sext_d   = sext_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        // Flush overrides hold; otherwise hold freezes the whole entry.
        if (ex_flush || !ex_hold) begin
            npc_d    = IF_ID_npcout;
            rd1_d    = rdata1;
            rd2_d    = rdata2;
            sext_d   = sext;
            rt_d     = rt_addr;
            rd_d     = rd_addr;
            wb_d     = bubble ? 2'b00 : dec_wb;
            m_d      = bubble ? 3'b000 : dec_m;
            regdst_d = bubble ? 1'b0 : dec_regdst;
            alusrc_d = bubble ? 1'b0 : dec_alusrc;
            aluop_d  = bubble ? 2'b00 : dec_aluop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q     <= '0;
            m_q      <= '0;
            regdst_q <= 1'b0;
            alusrc_q <= 1'b0;
            aluop_q  <= '0;
            npc_q    <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            sext_q   <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
        end else begin
            wb_q     <= wb_d;
            m_q      <= m_d;
            regdst_q <= regdst_d;
            alusrc_q <= alusrc_d;
            aluop_q  <= aluop_d;
            npc_q    <= npc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            sext_q   <= sext_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
        end
    end

    assign wb_ctlout     = wb_q;
    assign m_ctlout      = m_q;
    assign regdst        = regdst_q;
    assign alusrc        = alusrc_q;
    assign aluop         = aluop_q;
    assign npcout        = npc_q;
    assign rdata1out     = rd1_q;
    assign rdata2out     = rd2_q;
    assign s_extendout   = sext_q;
    assign instrout_2016 = rt_q;
    assign instrout_1511 = rd_q;

endmodule
